// File: rtl/vec_stream_pkg.sv
// Shared types and constants for the vector stream source.
package vec_stream_pkg;

  typedef enum logic [1:0] {
    VS_LOAD,
    VS_READY,
    VS_STREAM
  } vs_state_t;

  localparam int unsigned VS_FIFO_DEPTH = 2;

endpackage

// File: rtl/vs_mem.sv
// Vector storage: LEN x T, synchronous write, registered one-cycle read.
module vs_mem #(
  parameter int unsigned T   = 16,
  parameter int unsigned LEN = 112,
  parameter int unsigned AW  = $clog2(LEN)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [T-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [T-1:0]  rd_data
);

  logic [T-1:0] mem [LEN];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vec_stream_source.sv
// Buffers one LEN-word vector from the host port and replays it on x_data/x_valid/x_ready per start.
module vec_stream_source
  import vec_stream_pkg::*;
#(
  parameter int unsigned T   = 16,
  parameter int unsigned LEN = 112
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [T-1:0] ld_data,
  input  logic         ld_valid,
  output logic         ld_ready,
  input  logic         start,
  input  logic         reload,
  output logic         busy,
  output logic [T-1:0] x_data,
  output logic         x_valid,
  input  logic         x_ready,
  output logic         done
);

  localparam int unsigned AW = $clog2(LEN);
  localparam logic [AW-1:0] LAST = AW'(LEN - 1);

  vs_state_t state_q, state_d;

  logic [AW-1:0] ld_cnt_q, rd_addr_q, hs_cnt_q;
  logic          rd_all_q, inflight_q, done_q;
  logic [T-1:0]  fifo_q [VS_FIFO_DEPTH];
  logic          head_q, tail_q;
  logic [1:0]    cnt_q;

  logic          ld_fire, rd_en, hs, push, pop, fifo_empty;
  logic [2:0]    occ;
  logic [T-1:0]  mem_q;

  vs_mem #(
    .T  (T),
    .LEN(LEN),
    .AW (AW)
  ) u_mem (
    .clk    (clk),
    .wr_en  (ld_fire),
    .wr_addr(ld_cnt_q),
    .wr_data(ld_data),
    .rd_en  (rd_en),
    .rd_addr(rd_addr_q),
    .rd_data(mem_q)
  );

  // The memory output register acts as the first skid stage: with the FIFO empty it drives
  // x_data directly, and is captured into the FIFO only when it is not consumed that cycle.
  assign fifo_empty = (cnt_q == 2'd0);
  assign x_valid    = !fifo_empty || inflight_q;
  assign x_data     = fifo_empty ? mem_q : fifo_q[head_q];
  assign hs         = x_valid && x_ready;
  assign pop        = hs && !fifo_empty;
  assign push       = inflight_q && !(hs && fifo_empty);
  assign occ        = 3'(cnt_q) + 3'(inflight_q);
  assign rd_en      = (state_q == VS_STREAM) && !rd_all_q && (occ < 3'(VS_FIFO_DEPTH));
  assign ld_fire    = ld_valid && (state_q == VS_LOAD);
  assign ld_ready   = (state_q == VS_LOAD);
  assign busy       = (state_q == VS_STREAM);
  assign done       = done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= VS_LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      VS_LOAD:   if (ld_fire && ld_cnt_q == LAST) state_d = VS_READY;
      VS_READY: begin
        if (reload)     state_d = VS_LOAD;
        else if (start) state_d = VS_STREAM;
      end
      VS_STREAM: if (hs && hs_cnt_q == LAST) state_d = VS_READY;
      default:   state_d = VS_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_cnt_q   <= '0;
      rd_addr_q  <= '0;
      hs_cnt_q   <= '0;
      rd_all_q   <= 1'b0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      cnt_q      <= '0;
      for (int unsigned i = 0; i < VS_FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      done_q     <= (state_q == VS_STREAM) && hs && (hs_cnt_q == LAST);
      inflight_q <= rd_en;

      if (ld_fire) ld_cnt_q <= (ld_cnt_q == LAST) ? '0 : ld_cnt_q + 1'b1;

      if (state_q == VS_READY) begin
        rd_addr_q <= '0;
        rd_all_q  <= 1'b0;
        hs_cnt_q  <= '0;
        if (reload) ld_cnt_q <= '0;
      end else begin
        if (rd_en) begin
          if (rd_addr_q == LAST) rd_all_q <= 1'b1;
          else                   rd_addr_q <= rd_addr_q + 1'b1;
        end
        if (hs) hs_cnt_q <= hs_cnt_q + 1'b1;
      end

      if (push) begin
        fifo_q[tail_q] <= mem_q;
        tail_q         <= ~tail_q;
      end
      if (pop) head_q <= ~head_q;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_stream_source.sv
// Directed bench for vec_stream_source: LEN=4 instance for timing/protocol cases, LEN=112 for random traffic.
module tb_vec_stream_source;

  logic clk, rst;

  logic [15:0] a_ld_data, a_x_data, b_ld_data, b_x_data;
  logic a_ld_valid, a_ld_ready, a_start, a_reload, a_busy, a_x_valid, a_x_ready, a_done;
  logic b_ld_valid, b_ld_ready, b_start, b_reload, b_busy, b_x_valid, b_x_ready, b_done;

  int n_vec = 0;
  int n_err = 0;
  int hs_a = 0, done_a = 0, hs_b = 0, done_b = 0;
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  logic [15:0] model_b[112];

  vec_stream_source #(.T(16), .LEN(4)) u_a (
    .clk(clk), .reset(rst), .ld_data(a_ld_data), .ld_valid(a_ld_valid), .ld_ready(a_ld_ready),
    .start(a_start), .reload(a_reload), .busy(a_busy), .x_data(a_x_data), .x_valid(a_x_valid),
    .x_ready(a_x_ready), .done(a_done)
  );

  vec_stream_source #(.T(16), .LEN(112)) u_b (
    .clk(clk), .reset(rst), .ld_data(b_ld_data), .ld_valid(b_ld_valid), .ld_ready(b_ld_ready),
    .start(b_start), .reload(b_reload), .busy(b_busy), .x_data(b_x_data), .x_valid(b_x_valid),
    .x_ready(b_x_ready), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor A: scoreboard pop on handshake, hold checks while stalled.
  initial begin
    logic        stall;
    logic [15:0] hold;
    logic [31:0] e;
    stall = 1'b0;
    hold  = '0;
    forever begin
      @(negedge clk);
      if (rst) stall = 1'b0;
      else begin
        if (stall) begin
          check("a_hold_valid", 32'(a_x_valid), 32'd1);
          check("a_hold_data", 32'(a_x_data), 32'(hold));
        end
        if (a_x_valid && a_x_ready) begin
          hs_a++;
          if (exp_a.size() > 0) e = 32'(exp_a.pop_front());
          else e = 'x;
          check("a_word", 32'(a_x_data), e);
        end
        if (a_done) done_a++;
        stall = a_x_valid && !a_x_ready;
        hold  = a_x_data;
      end
    end
  end

  // Monitor B.
  initial begin
    logic        stall;
    logic [15:0] hold;
    logic [31:0] e;
    stall = 1'b0;
    hold  = '0;
    forever begin
      @(negedge clk);
      if (rst) stall = 1'b0;
      else begin
        if (stall) begin
          check("b_hold_valid", 32'(b_x_valid), 32'd1);
          check("b_hold_data", 32'(b_x_data), 32'(hold));
        end
        if (b_x_valid && b_x_ready) begin
          hs_b++;
          if (exp_b.size() > 0) e = 32'(exp_b.pop_front());
          else e = 'x;
          check("b_word", 32'(b_x_data), e);
        end
        if (b_done) done_b++;
        stall = b_x_valid && !b_x_ready;
        hold  = b_x_data;
      end
    end
  end

  initial begin
    int hs_base, done_base;
    bit pat[7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    rst = 1'b1;
    a_ld_data = '0; a_ld_valid = 1'b0; a_start = 1'b0; a_reload = 1'b0; a_x_ready = 1'b0;
    b_ld_data = '0; b_ld_valid = 1'b0; b_start = 1'b0; b_reload = 1'b0; b_x_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();
    check("rst_ld_ready", 32'(a_ld_ready), 32'd1);
    check("rst_x_valid", 32'(a_x_valid), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);

    // 1: load with gaps, stream under x_ready=1, exact latency
    for (int i = 0; i < 4; i++) begin
      a_ld_data = 16'((i + 1) * 10);
      a_ld_valid = 1'b1;
      check("t1_ld_ready_loading", 32'(a_ld_ready), 32'd1);
      step();
      a_ld_valid = 1'b0;
      if (i < 3) step();
    end
    check("t1_ld_ready_after", 32'(a_ld_ready), 32'd0);
    for (int i = 0; i < 4; i++) exp_a.push_back(16'((i + 1) * 10));
    hs_base = hs_a; done_base = done_a;
    a_x_ready = 1'b1;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    check("t1_busy", 32'(a_busy), 32'd1);
    check("t1_valid_t1", 32'(a_x_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t1_valid", 32'(a_x_valid), 32'd1);
      check("t1_data", 32'(a_x_data), 32'((i + 1) * 10));
      check("t1_no_early_done", 32'(a_done), 32'd0);
    end
    step();
    check("t1_done", 32'(a_done), 32'd1);
    check("t1_valid_end", 32'(a_x_valid), 32'd0);
    check("t1_busy_end", 32'(a_busy), 32'd0);
    step();
    check("t1_done_pulse", 32'(a_done), 32'd0);
    check("t1_hs", 32'(hs_a - hs_base), 32'd4);
    check("t1_ndone", 32'(done_a - done_base), 32'd1);

    // 2: backpressure pattern
    for (int i = 0; i < 4; i++) exp_a.push_back(16'((i + 1) * 10));
    hs_base = hs_a; done_base = done_a;
    a_x_ready = 1'b0;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    step();
    for (int i = 0; i < 40 && done_a == done_base; i++) begin
      a_x_ready = (i < 7) ? pat[i] : 1'b1;
      step();
    end
    step();
    check("t2_hs", 32'(hs_a - hs_base), 32'd4);
    check("t2_ndone", 32'(done_a - done_base), 32'd1);
    check("t2_sb_empty", 32'(exp_a.size()), 32'd0);

    // 3: replay without reload; start during stream ignored
    for (int i = 0; i < 4; i++) exp_a.push_back(16'((i + 1) * 10));
    hs_base = hs_a; done_base = done_a;
    a_x_ready = 1'b1;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    step();
    step();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    for (int i = 0; i < 40 && done_a == done_base; i++) step();
    repeat (3) step();
    check("t3_busy_after", 32'(a_busy), 32'd0);
    check("t3_valid_after", 32'(a_x_valid), 32'd0);
    check("t3_hs", 32'(hs_a - hs_base), 32'd4);
    check("t3_ndone", 32'(done_a - done_base), 32'd1);

    // 4: start and reload together -> reload wins
    a_start = 1'b1;
    a_reload = 1'b1;
    step();
    a_start = 1'b0;
    a_reload = 1'b0;
    check("t4_ld_ready", 32'(a_ld_ready), 32'd1);
    check("t4_busy", 32'(a_busy), 32'd0);
    check("t4_valid", 32'(a_x_valid), 32'd0);
    step();
    check("t4_valid2", 32'(a_x_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      a_ld_data = 16'(i + 1);
      a_ld_valid = 1'b1;
      step();
    end
    a_ld_valid = 1'b0;
    check("t4_ld_ready_after", 32'(a_ld_ready), 32'd0);
    for (int i = 0; i < 4; i++) exp_a.push_back(16'(i + 1));
    hs_base = hs_a; done_base = done_a;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    for (int i = 0; i < 40 && done_a == done_base; i++) step();
    step();
    check("t4_hs", 32'(hs_a - hs_base), 32'd4);
    check("t4_ndone", 32'(done_a - done_base), 32'd1);
    check("t4_sb_empty", 32'(exp_a.size()), 32'd0);

    // 5: async reset after the second handshake
    for (int i = 0; i < 4; i++) exp_a.push_back(16'(i + 1));
    hs_base = hs_a; done_base = done_a;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    repeat (3) step();
    check("t5_pre_hs", 32'(hs_a - hs_base), 32'd2);
    check("t5_pre_valid", 32'(a_x_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("t5_valid_rst", 32'(a_x_valid), 32'd0);
    check("t5_busy_rst", 32'(a_busy), 32'd0);
    check("t5_ld_ready_rst", 32'(a_ld_ready), 32'd1);
    exp_a.delete();
    step();
    #1 rst = 1'b0;
    repeat (3) step();
    check("t5_ld_ready", 32'(a_ld_ready), 32'd1);
    check("t5_busy", 32'(a_busy), 32'd0);
    check("t5_valid", 32'(a_x_valid), 32'd0);
    check("t5_no_done", 32'(done_a - done_base), 32'd0);

    // 6: LEN=112, random data, gaps, and random x_ready
    for (int i = 0; i < 112; i++) begin
      while ($urandom_range(0, 3) == 0) step();
      model_b[i] = 16'($urandom);
      b_ld_data = model_b[i];
      b_ld_valid = 1'b1;
      step();
      b_ld_valid = 1'b0;
    end
    check("t6_ld_ready_after", 32'(b_ld_ready), 32'd0);
    for (int i = 0; i < 112; i++) exp_b.push_back(model_b[i]);
    hs_base = hs_b; done_base = done_b;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int i = 0; i < 2000 && done_b == done_base; i++) begin
      b_x_ready = 1'($urandom_range(0, 1));
      step();
    end
    repeat (5) begin
      b_x_ready = 1'($urandom_range(0, 1));
      step();
    end
    check("t6_hs", 32'(hs_b - hs_base), 32'd112);
    check("t6_ndone", 32'(done_b - done_base), 32'd1);
    check("t6_sb_empty", 32'(exp_b.size()), 32'd0);
    check("t6_busy_end", 32'(b_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
